// File: rtl/oam_dma_pkg.sv
// Shared constants, state encoding and source-page helper for the OAM DMA block.
package oam_dma_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 8;

   localparam logic [ADDR_W-1:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [ADDR_W-1:0] OAM_BASE     = 16'hFE00;
   localparam logic [ADDR_W-1:0] HRAM_LO      = 16'hFF80;
   localparam logic [ADDR_W-1:0] HRAM_HI      = 16'hFFFE;
   localparam int unsigned       DMA_LEN      = 160;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } dma_state_t;

   // Pages E0-FF mirror C0-DF; the register keeps the raw value.
   function automatic logic [DATA_W-1:0] dma_eff_page(input logic [DATA_W-1:0] v);
      return (v >= 8'hE0) ? DATA_W'(v - 8'h20) : v;
   endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// DMA sequencer: START, then READ/WRITE pairs over idx 0..DMA_LEN-1.
module oam_dma_engine
   import oam_dma_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [DATA_W-1:0]    i_page,
   output dma_state_t           o_state,
   output logic [IDX_W-1:0]     o_idx,
   output logic [ADDR_W-1:0]    o_src_addr,
   output logic                 o_active
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);

   dma_state_t          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [DATA_W-1:0]   r_page;

   // A start request wins in every state, so a rewrite restarts from idx 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_page  <= '0;
      end else if (i_start) begin
         r_state <= START;
         r_idx   <= '0;
         r_page  <= i_page;
      end else begin
         case (r_state)
            IDLE: ;
            START: begin
               r_idx   <= '0;
               r_state <= READ;
            end
            READ:  r_state <= WRITE;
            WRITE: begin
               if (r_idx == IDX_LAST) begin
                  r_state <= IDLE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_state <= READ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_state    = r_state;
   assign o_idx      = r_idx;
   assign o_src_addr = {r_page, r_idx};
   assign o_active   = (r_state != IDLE);

endmodule

// File: rtl/oam_dma.sv
// OAM DMA top: FF46 source register, CPU/DMA memory-bus mux and CPU read-back path.
module oam_dma
   import oam_dma_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    cpu_addr,
   input  logic [DATA_W-1:0]    cpu_wdata,
   input  logic                 cpu_re,
   input  logic                 cpu_we,
   output logic [DATA_W-1:0]    cpu_rdata,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic                 mem_re,
   output logic                 mem_we,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 dma_active
);

   logic [DATA_W-1:0]   r_src;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rd_mem;

   logic                w_is_reg;
   logic                w_is_hram;
   logic                w_start;
   logic                w_cpu_mem_re;
   logic                w_cpu_mem_we;
   dma_state_t          w_state;
   logic [IDX_W-1:0]    w_idx;
   logic [ADDR_W-1:0]   w_src_addr;
   logic                w_active;

   assign w_is_reg     = (cpu_addr == DMA_REG_ADDR);
   assign w_is_hram    = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
   assign w_start      = cpu_we && w_is_reg;
   assign w_cpu_mem_we = cpu_we && !w_is_reg;
   assign w_cpu_mem_re = cpu_re && !cpu_we && !w_is_reg;

   oam_dma_engine u_engine (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_start),
      .i_page     (dma_eff_page(cpu_wdata)),
      .o_state    (w_state),
      .o_idx      (w_idx),
      .o_src_addr (w_src_addr),
      .o_active   (w_active)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src <= '0;
      end else if (w_start) begin
         r_src <= cpu_wdata;
      end
   end

   // Read-back: register value, 8'hFF while the bus is owned by DMA, or memory data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata  <= '0;
         r_rd_mem <= 1'b0;
      end else begin
         r_rd_mem <= 1'b0;
         if (cpu_re && w_is_reg) begin
            r_rdata <= r_src;
         end else if (w_active) begin
            if (cpu_re && !w_is_hram) begin
               r_rdata <= 8'hFF;
            end
         end else if (w_cpu_mem_re) begin
            r_rd_mem <= 1'b1;
         end
      end
   end

   assign cpu_rdata  = r_rd_mem ? mem_rdata : r_rdata;
   assign dma_active = w_active;

   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      case (w_state)
         IDLE: begin
            mem_re = w_cpu_mem_re;
            mem_we = w_cpu_mem_we;
         end
         START: mem_addr = OAM_BASE;
         READ: begin
            mem_addr = w_src_addr;
            mem_re   = 1'b1;
         end
         WRITE: begin
            mem_addr  = OAM_BASE + ADDR_W'(w_idx);
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
         end
         default: ;
      endcase
      // Strobes must drop the instant reset asserts, even on a CPU pass-through.
      if (rst) begin
         mem_re = 1'b0;
         mem_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a behavioural one-cycle-latency memory.
module tb_oam_dma;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_re;
   logic        cpu_we;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        dma_active;

   logic [7:0]  mem [0:65535];
   logic        pl_we;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;

   int checks = 0;
   int errors = 0;
   int act_total = 0;
   int overlap = 0;
   int bad_we = 0;

   oam_dma dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .dma_active (dma_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with a bench-only preload port; read data appears the cycle after mem_re.
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   always @(posedge clk) begin
      if (dma_active) act_total <= act_total + 1;
      if (mem_re && mem_we) overlap <= overlap + 1;
      if (dma_active && mem_we && (mem_addr < 16'hFE00 || mem_addr > 16'hFE9F))
         bad_we <= bad_we + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(posedge clk); #1;
      pl_we   = 1'b0;
   endtask

   task automatic fill_oam();
      for (int i = 0; i < 192; i++) poke(16'(16'hFE00 + i), 8'hEE);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_we    = 1'b1;
      @(posedge clk); #1;
      cpu_we    = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      cpu_addr = a;
      cpu_re   = 1'b1;
      @(posedge clk); #1;
      cpu_re   = 1'b0;
      d        = cpu_rdata;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (dma_active && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      check("dma_done_in_time", 32'(dma_active), 32'd0);
   endtask

   function automatic logic [7:0] exp_byte(input logic [7:0] page, input int i);
      case (page)
         8'hC0:   return 8'(i) ^ 8'h5A;
         8'hC1:   return 8'(i) ^ 8'hA5;
         default: return 8'(i * 3 + 1);
      endcase
   endfunction

   function automatic int oam_diff(input logic [7:0] page);
      int n = 0;
      for (int i = 0; i < 160; i++)
         if (mem[16'hFE00 + i] !== exp_byte(page, i)) n++;
      return n;
   endfunction

   initial begin
      logic [7:0] rd;
      int a0;
      int n;
      rst = 1'b1; cpu_addr = 16'hC000; cpu_wdata = '0; cpu_re = 1'b1; cpu_we = 1'b0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (3) @(posedge clk); #1;
      check("reset_active", 32'(dma_active), 32'd0);
      check("reset_rdata", 32'(cpu_rdata), 32'h00);
      check("reset_mem_re_gated", 32'(mem_re), 32'd0);
      cpu_re = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 160; i++) begin
         poke(16'(16'hC000 + i), exp_byte(8'hC0, i));
         poke(16'(16'hC100 + i), exp_byte(8'hC1, i));
         poke(16'(16'hD000 + i), exp_byte(8'hD0, i));
      end
      poke(16'h8000, 8'h12);
      fill_oam();
      check("no_start_after_reset", 32'(dma_active), 32'd0);
      cpu_read(16'hFF46, rd);
      check("ff46_after_reset", 32'(rd), 32'h00);
      cpu_read(16'hC005, rd);
      check("idle_passthrough_read", 32'(rd), 32'h5F);

      // Basic copy from page C0
      a0 = act_total;
      cpu_write(16'hFF46, 8'hC0);
      check("active_after_write", 32'(dma_active), 32'd1);
      wait_idle(400);
      check("active_cycles_c0", 32'(act_total - a0), 32'd321);
      check("oam_c0_diffs", 32'(oam_diff(8'hC0)), 32'd0);
      check("fea0_untouched", 32'(mem[16'hFEA0]), 32'hEE);
      cpu_read(16'hFE10, rd);
      check("oam_readback_fe10", 32'(rd), 32'h4A);

      // Mirror page E1 copies C1
      fill_oam();
      cpu_write(16'hFF46, 8'hE1);
      wait_idle(400);
      check("oam_e1_diffs", 32'(oam_diff(8'hC1)), 32'd0);
      cpu_read(16'hFF46, rd);
      check("ff46_raw_e1", 32'(rd), 32'hE1);

      // CPU traffic during a transfer
      fill_oam();
      cpu_write(16'hFF46, 8'hC0);
      repeat (10) @(posedge clk); #1;
      cpu_read(16'h8000, rd);
      check("blocked_read_ff", 32'(rd), 32'hFF);
      cpu_write(16'hC100, 8'h33);
      cpu_read(16'hFF46, rd);
      check("ff46_read_during_dma", 32'(rd), 32'hC0);
      wait_idle(400);
      check("c100_unchanged", 32'(mem[16'hC100]), 32'hA5);
      check("oam_c0_with_traffic", 32'(oam_diff(8'hC0)), 32'd0);

      // Restart: new write lands on the edge where idx would advance to 50
      fill_oam();
      a0 = act_total;
      cpu_write(16'hFF46, 8'hC0);
      repeat (100) @(posedge clk); #1;
      check("idx49_write_strobe", 32'(mem_we), 32'd1);
      check("idx49_write_addr", 32'(mem_addr), 32'hFE31);
      cpu_write(16'hFF46, 8'hD0);
      wait_idle(500);
      check("active_cycles_restart", 32'(act_total - a0), 32'd422);
      check("oam_d0_diffs", 32'(oam_diff(8'hD0)), 32'd0);

      // Reset in the middle of a transfer, at idx 80
      fill_oam();
      cpu_write(16'hFF46, 8'hC0);
      repeat (161) @(posedge clk); #1;
      check("idx80_read_strobe", 32'(mem_re), 32'd1);
      check("idx80_read_addr", 32'(mem_addr), 32'hC050);
      #2 rst = 1'b1;
      #1;
      check("rst_kills_active", 32'(dma_active), 32'd0);
      check("rst_kills_re", 32'(mem_re), 32'd0);
      check("rst_kills_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("fe4f_written", 32'(mem[16'hFE4F]), 32'h15);
      n = 0;
      for (int i = 16'hFE50; i <= 16'hFE9F; i++) if (mem[i] !== 8'hEE) n++;
      check("fe50_on_untouched", 32'(n), 32'd0);
      cpu_read(16'hFF46, rd);
      check("ff46_after_mid_reset", 32'(rd), 32'h00);
      repeat (10) @(posedge clk); #1;
      check("no_restart_after_reset", 32'(dma_active), 32'd0);

      // Random CPU traffic, during and after a transfer
      cpu_write(16'hFF46, 8'hC0);
      for (int k = 0; k < 300; k++) begin
         cpu_addr  = 16'($urandom);
         if (cpu_addr == 16'hFF46) cpu_addr = 16'h0000;
         cpu_wdata = 8'($urandom);
         cpu_re    = 1'($urandom);
         cpu_we    = 1'($urandom);
         @(posedge clk); #1;
      end
      cpu_re = 1'b0;
      cpu_we = 1'b0;
      wait_idle(400);
      check("strobe_overlap_count", 32'(overlap), 32'd0);
      check("dma_write_outside_oam", 32'(bad_we), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
